// File: rtl/branch_compare_stage.sv
// EX/MEM branch-compare stage: signed/unsigned operand compare in EX, registered
// flags, type and target for MEM-stage resolution, plus saturating retire counters.
module branch_compare_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             stall,
  input  logic             flush,
  input  logic             resolve,
  input  logic             cnt_clear,
  output logic             mem_valid,
  output logic             mem_equal,
  output logic             mem_greater,
  output logic             mem_lesser,
  output logic [2:0]       mem_branch_type,
  output logic [XLEN-1:0]  mem_target,
  output logic             mem_illegal,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Operands widened by one bit so a single signed compare covers both
  // signedness modes: unsigned zero-extends, signed sign-extends.
  logic signed [XLEN:0] rs1_x;
  logic signed [XLEN:0] rs2_x;
  logic                 ex_eq;
  logic                 ex_lt;
  logic                 ex_reserved;
  logic                 load_valid;

  always_comb begin
    rs1_x       = $signed({ex_funct3[1] ? 1'b0 : ex_rs1[XLEN-1], ex_rs1});
    rs2_x       = $signed({ex_funct3[1] ? 1'b0 : ex_rs2[XLEN-1], ex_rs2});
    ex_eq       = (ex_rs1 == ex_rs2);
    ex_lt       = (rs1_x < rs2_x);
    ex_reserved = (ex_funct3[2:1] == 2'b01);
    load_valid  = ex_valid & ex_is_branch;
  end

  // EX -> MEM boundary
  logic             mem_valid_q,   mem_valid_d;
  logic             mem_equal_q,   mem_equal_d;
  logic             mem_greater_q, mem_greater_d;
  logic             mem_lesser_q,  mem_lesser_d;
  logic [2:0]       mem_type_q,    mem_type_d;
  logic [XLEN-1:0]  mem_target_q,  mem_target_d;
  logic             mem_illegal_q, mem_illegal_d;
  logic [CNT_W-1:0] branch_cnt_q,  branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q,   taken_cnt_d;
  logic             retire;

  always_comb begin
    mem_valid_d   = mem_valid_q;
    mem_equal_d   = mem_equal_q;
    mem_greater_d = mem_greater_q;
    mem_lesser_d  = mem_lesser_q;
    mem_type_d    = mem_type_q;
    mem_target_d  = mem_target_q;
    mem_illegal_d = mem_illegal_q;
    if (flush) begin
      mem_valid_d   = 1'b0;
      mem_illegal_d = 1'b0;
    end else if (!stall) begin
      mem_valid_d   = load_valid;
      mem_equal_d   = load_valid & ~ex_reserved & ex_eq;
      mem_lesser_d  = load_valid & ~ex_reserved & ex_lt;
      mem_greater_d = load_valid & ~ex_reserved & ~ex_eq & ~ex_lt;
      mem_type_d    = ex_funct3;
      mem_target_d  = ex_target;
      mem_illegal_d = load_valid & ex_reserved;
    end
  end

  // Counters look at the branch currently in MEM; flush only kills the incoming one.
  always_comb begin
    retire       = mem_valid_q & ~stall & ~mem_illegal_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (cnt_clear) begin
      branch_cnt_d = '0;
      taken_cnt_d  = '0;
    end else if (retire) begin
      branch_cnt_d = sat_inc(branch_cnt_q);
      if (resolve) taken_cnt_d = sat_inc(taken_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_q   <= 1'b0;
      mem_equal_q   <= 1'b0;
      mem_greater_q <= 1'b0;
      mem_lesser_q  <= 1'b0;
      mem_type_q    <= 3'b000;
      mem_target_q  <= '0;
      mem_illegal_q <= 1'b0;
      branch_cnt_q  <= '0;
      taken_cnt_q   <= '0;
    end else begin
      mem_valid_q   <= mem_valid_d;
      mem_equal_q   <= mem_equal_d;
      mem_greater_q <= mem_greater_d;
      mem_lesser_q  <= mem_lesser_d;
      mem_type_q    <= mem_type_d;
      mem_target_q  <= mem_target_d;
      mem_illegal_q <= mem_illegal_d;
      branch_cnt_q  <= branch_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign mem_valid       = mem_valid_q;
  assign mem_equal       = mem_equal_q;
  assign mem_greater     = mem_greater_q;
  assign mem_lesser      = mem_lesser_q;
  assign mem_branch_type = mem_type_q;
  assign mem_target      = mem_target_q;
  assign mem_illegal     = mem_illegal_q;
  assign branch_count    = branch_cnt_q;
  assign taken_count     = taken_cnt_q;

endmodule

// File: tb/tb_branch_compare_stage.sv
// Directed bench for branch_compare_stage: vector table for the compare flags,
// hand-written sequences for stall/flush, counters, saturation and async reset.
module tb_branch_compare_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_branch;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2, ex_target;
  logic        stall, flush, resolve, cnt_clear;

  logic        mv, meq, mgt, mlt, mill;
  logic [2:0]  mtype;
  logic [31:0] mtgt, bcnt, tcnt;
  logic        mv4, meq4, mgt4, mlt4, mill4;
  logic [2:0]  mtype4;
  logic [31:0] mtgt4;
  logic [3:0]  bcnt4, tcnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_compare_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_target(ex_target),
    .stall(stall), .flush(flush), .resolve(resolve), .cnt_clear(cnt_clear),
    .mem_valid(mv), .mem_equal(meq), .mem_greater(mgt), .mem_lesser(mlt),
    .mem_branch_type(mtype), .mem_target(mtgt), .mem_illegal(mill),
    .branch_count(bcnt), .taken_count(tcnt)
  );

  branch_compare_stage #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_target(ex_target),
    .stall(stall), .flush(flush), .resolve(resolve), .cnt_clear(cnt_clear),
    .mem_valid(mv4), .mem_equal(meq4), .mem_greater(mgt4), .mem_lesser(mlt4),
    .mem_branch_type(mtype4), .mem_target(mtgt4), .mem_illegal(mill4),
    .branch_count(bcnt4), .taken_count(tcnt4)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] t;
    logic        eq;
    logic        gt;
    logic        lt;
    logic        ill;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic br, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] t);
    ex_valid     = v;
    ex_is_branch = br;
    ex_funct3    = f3;
    ex_rs1       = a;
    ex_rs2       = b;
    ex_target    = t;
  endtask

  // {valid, equal, greater, lesser, illegal}
  function automatic logic [4:0] flags();
    return {mv, meq, mgt, mlt, mill};
  endfunction

  logic r_pat[5];

  initial begin
    vecs[0] = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0200, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{3'b000, 32'h0000_1234, 32'h0000_1234, 32'hCAFE_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{3'b001, 32'h0000_0005, 32'h0000_0007, 32'h0000_0300, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{3'b101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0400, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0500, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{3'b010, 32'h0000_0001, 32'h0000_0002, 32'h0000_0600, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{3'b011, 32'h0000_0009, 32'h0000_0009, 32'h0000_0700, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{3'b100, 32'h0000_0007, 32'h0000_0007, 32'h0000_0800, 1'b1, 1'b0, 1'b0, 1'b0};
    r_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    stall = 1'b0; flush = 1'b0; resolve = 1'b0; cnt_clear = 1'b0;
    drive(1'b1, 1'b1, 3'b000, 32'h1, 32'h1, 32'hDEAD_BEEF);
    #12;
    chk("reset_flags", flags(), 5'b00000);
    chk("reset_type", mtype, 3'b000);
    chk("reset_target", mtgt, 32'h0);
    chk("reset_bcnt", bcnt, 32'h0);
    chk("reset_tcnt", tcnt, 32'h0);
    rst_n = 1'b1;

    // non-branch and invalid EX slots never load a live MEM branch
    drive(1'b1, 1'b0, 3'b000, 32'h3, 32'h3, 32'h10);
    tick();
    chk("nonbranch_flags", flags(), 5'b00000);
    drive(1'b0, 1'b1, 3'b100, 32'h1, 32'h2, 32'h20);
    tick();
    chk("invalid_flags", flags(), 5'b00000);

    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].t);
      tick();
      chk($sformatf("vec%0d_flags", i), flags(),
          {1'b1, vecs[i].eq, vecs[i].gt, vecs[i].lt, vecs[i].ill});
      chk($sformatf("vec%0d_type", i), mtype, vecs[i].f3);
      chk($sformatf("vec%0d_target", i), mtgt, vecs[i].t);
    end

    // stall holds MEM for 3 cycles, then stall+flush kills it
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("clr_bcnt", bcnt, 32'h0);
    drive(1'b1, 1'b1, 3'b100, 32'h1, 32'h2, 32'hA000);
    tick();
    chk("stallA_flags", flags(), 5'b10010);
    drive(1'b1, 1'b1, 3'b000, 32'h5, 32'h5, 32'hB000);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall%0d_flags", k), flags(), 5'b10010);
      chk($sformatf("stall%0d_type", k), mtype, 3'b100);
      chk($sformatf("stall%0d_target", k), mtgt, 32'hA000);
      chk($sformatf("stall%0d_bcnt", k), bcnt, 32'h0);
    end
    flush = 1'b1;
    tick();
    chk("stallflush_valid", mv, 1'b0);
    chk("stallflush_ill", mill, 1'b0);
    chk("stallflush_bcnt", bcnt, 32'h0);
    stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    tick();

    // five retiring branches, resolve pattern 1,0,1,1,0
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 3'b000, k, k, 32'h100 + k);
      resolve = (k > 0) ? r_pat[k-1] : 1'b0;
      tick();
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    resolve = r_pat[4];
    tick();
    resolve = 1'b0;
    chk("five_bcnt", bcnt, 32'd5);
    chk("five_tcnt", tcnt, 32'd3);

    // clear wins over a simultaneous taken retire
    drive(1'b1, 1'b1, 3'b000, 32'h1, 32'h1, 32'h40);
    tick();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    cnt_clear = 1'b1; resolve = 1'b1;
    tick();
    cnt_clear = 1'b0; resolve = 1'b0;
    chk("clrret_bcnt", bcnt, 32'h0);
    chk("clrret_tcnt", tcnt, 32'h0);

    // flush kills the incoming branch but the MEM branch still counts
    drive(1'b1, 1'b1, 3'b000, 32'h2, 32'h2, 32'h50);
    tick();
    flush = 1'b1; resolve = 1'b1;
    tick();
    flush = 1'b0; resolve = 1'b0;
    chk("flushcnt_valid", mv, 1'b0);
    chk("flushcnt_bcnt", bcnt, 32'd1);
    chk("flushcnt_tcnt", tcnt, 32'd1);

    // 20 taken retires: 4-bit counters saturate at 15
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 3'b111, 32'h9, k, 32'h600 + k);
      resolve = (k > 0);
      tick();
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    resolve = 1'b1;
    tick();
    resolve = 1'b0;
    chk("sat4_bcnt", bcnt4, 4'd15);
    chk("sat4_tcnt", tcnt4, 4'd15);
    chk("sat32_bcnt", bcnt, 32'd20);
    chk("sat32_tcnt", tcnt, 32'd20);

    // illegal funct3 in MEM does not retire
    drive(1'b1, 1'b1, 3'b011, 32'h1, 32'h2, 32'h900);
    tick();
    chk("illegal_flags", flags(), 5'b10001);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    resolve = 1'b1;
    tick();
    resolve = 1'b0;
    chk("illegal_bcnt", bcnt, 32'd20);
    chk("illegal_tcnt", tcnt, 32'd20);

    // async reset between edges while MEM holds a live branch
    drive(1'b1, 1'b1, 3'b101, 32'h3, 32'h1, 32'hF00);
    tick();
    chk("prereset_flags", flags(), 5'b10100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_flags", flags(), 5'b00000);
    chk("async_target", mtgt, 32'h0);
    chk("async_bcnt", bcnt, 32'h0);
    chk("async_tcnt", tcnt, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    chk("postreset_flags", flags(), 5'b10100);
    chk("postreset_target", mtgt, 32'hF00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
